tb_irq_arbiter: RTL and testbench

Multi-source interrupt arbiter for the TramelBlaze counter system. It shares the processor's single `interrupt`/`interrupt_ack` pair among N event sources. Each source's rising edge is latched as a pending event, and one source is granted at a time in round-robin order. The granted source's ID is held stable for the ISR until firmware signals completion through an output-port write.

---
 rtl/tb_irq_arbiter.sv | 109 ++++++++++
 tb/tb_tb_irq_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tb_irq_arbiter.sv
// Round-robin interrupt arbiter sharing one interrupt/interrupt_ack pair among N
// edge-triggered event sources; the granted ID is held until the ISR signals done.
//
// state   | meaning
// IDLE    | no grant outstanding; arbitrate when anything is pending
// REQ     | interrupt raised for irq_id, waiting for ack
// SERVICE | ISR running for irq_id, waiting for done
module tb_irq_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            ack,
    input  logic            done,
    input  logic            ovf_clr,
    output logic            interrupt,
    output logic [ID_W-1:0] irq_id,
    output logic            in_service,
    output logic [N-1:0]    pending,
    output logic [N-1:0]    overflow
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t          state, state_nxt;
    logic [N-1:0]    req_d;
    logic [N-1:0]    req_edge;
    logic [N-1:0]    clr_mask;
    logic [N-1:0]    ovf_set;
    logic [N-1:0]    pending_nxt;
    logic [ID_W-1:0] last;
    logic [ID_W-1:0] pick;
    logic            grant;

    assign req_edge = req & ~req_d;
    assign clr_mask = (state == REQ && ack) ? ({{(N-1){1'b0}}, 1'b1} << irq_id) : '0;
    // A fresh edge on the bit being acked is a new event, not an overflow.
    assign ovf_set     = req_edge & pending & ~clr_mask;
    assign pending_nxt = req_edge | (pending & ~clr_mask);
    assign grant       = (state == IDLE) && (|pending);

    always_comb begin
        logic found;
        int   idx;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!found && pending[idx[ID_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_d    <= '0;
            pending  <= '0;
            overflow <= '0;
        end else begin
            req_d    <= req;
            pending  <= pending_nxt;
            overflow <= ovf_set | (ovf_clr ? '0 : overflow);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_id <= '0;
            last   <= ID_W'(N - 1);
        end else if (grant) begin
            irq_id <= pick;
            last   <= pick;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|pending) state_nxt = REQ;
            REQ:     if (ack)      state_nxt = SERVICE;
            SERVICE: if (done)     state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_comb begin
        interrupt  = 1'b0;
        in_service = 1'b0;
        case (state)
            REQ:     interrupt  = 1'b1;
            SERVICE: in_service = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tb_irq_arbiter.sv
// Directed bench for tb_irq_arbiter: reset, single event, round-robin order,
// overflow handling, ack collision and protocol noise.
module tb_tb_irq_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       ack = 1'b0;
    logic       done = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       interrupt;
    logic [1:0] irq_id;
    logic       in_service;
    logic [3:0] pending;
    logic [3:0] overflow;

    int tests = 0;
    int fails = 0;

    tb_irq_arbiter #(.N(4), .ID_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .ack        (ack),
        .done       (done),
        .ovf_clr    (ovf_clr),
        .interrupt  (interrupt),
        .irq_id     (irq_id),
        .in_service (in_service),
        .pending    (pending),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered with the arbiter in REQ for the given source; runs ack then done.
    task automatic serve(input string tag, input logic [1:0] id);
        check({tag, " int"}, 32'(interrupt), 32'h1);
        check({tag, " id"}, 32'(irq_id), 32'(id));
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check({tag, " int after ack"}, 32'(interrupt), 32'h0);
        check({tag, " in_service"}, 32'(in_service), 32'h1);
        check({tag, " id held"}, 32'(irq_id), 32'(id));
        done = 1'b1;
        tick();
        done = 1'b0;
        check({tag, " done"}, 32'(in_service), 32'h0);
    endtask

    initial begin
        int cnt;

        // Reset with req[3] already high: counts as one edge after release.
        req = 4'b1000;
        #2 rst = 1'b0;
        tick();
        tick();
        check("rst int", 32'(interrupt), 32'h0);
        check("rst insvc", 32'(in_service), 32'h0);
        check("rst id", 32'(irq_id), 32'h0);
        check("rst pend", 32'(pending), 32'h0);
        check("rst ovf", 32'(overflow), 32'h0);
        rst = 1'b1;
        tick();
        check("hi-at-rst pend", 32'(pending), 32'h8);
        check("hi-at-rst int0", 32'(interrupt), 32'h0);
        tick();
        serve("hi-at-rst", 2'd3);
        tick();
        check("held no re-event", 32'(interrupt), 32'h0);
        check("held pend", 32'(pending), 32'h0);

        // ack while idle does nothing
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("ack idle int", 32'(interrupt), 32'h0);
        check("ack idle insvc", 32'(in_service), 32'h0);
        req = 4'b0000;
        tick();

        // Asynchronous reset in the middle of REQ
        req = 4'b1011;
        tick();
        check("pre-rst pend", 32'(pending), 32'hB);
        tick();
        check("pre-rst int", 32'(interrupt), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("async int", 32'(interrupt), 32'h0);
        check("async pend", 32'(pending), 32'h0);
        check("async ovf", 32'(overflow), 32'h0);
        check("async id", 32'(irq_id), 32'h0);
        req = 4'b0000;
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        tick();
        tick();
        check("post-rst idle int", 32'(interrupt), 32'h0);
        check("post-rst idle pend", 32'(pending), 32'h0);

        // Round robin: 0,1,3 together, then a new 0 during service of 1
        req = 4'b1011;
        tick();
        req = 4'b0000;
        check("rr pend", 32'(pending), 32'hB);
        tick();
        serve("rr g0", 2'd0);
        check("rr pend after 0", 32'(pending), 32'hA);
        tick();
        check("rr g1 int", 32'(interrupt), 32'h1);
        check("rr g1 id", 32'(irq_id), 32'h1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("rr pend after 1", 32'(pending), 32'h8);
        req = 4'b0001;
        tick();
        req = 4'b0000;
        check("rr new0 pend", 32'(pending), 32'h9);
        check("rr g1 insvc", 32'(in_service), 32'h1);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("rr gap", 32'(interrupt), 32'h0);
        tick();
        serve("rr g3", 2'd3);
        tick();
        serve("rr g0b", 2'd0);
        tick();
        check("rr drained", 32'(interrupt), 32'h0);
        check("rr drained pend", 32'(pending), 32'h0);

        // Overflow: second edge on req[1] while pending
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick();
        req = 4'b0010;
        tick();
        req = 4'b0000;
        check("ovf set", 32'(overflow), 32'h2);
        check("ovf pend", 32'(pending), 32'h2);
        serve("ovf", 2'd1);
        tick();
        check("ovf one irq", 32'(interrupt), 32'h0);
        check("ovf sticky", 32'(overflow), 32'h2);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf clr", 32'(overflow), 32'h0);
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick();
        req = 4'b0010;
        ovf_clr = 1'b1;
        tick();
        req = 4'b0000;
        ovf_clr = 1'b0;
        check("ovf beats clr", 32'(overflow), 32'h2);
        serve("ovf2", 2'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;

        // Ack collision on source 2
        req = 4'b0100;
        tick();
        req = 4'b0000;
        tick();
        check("col id", 32'(irq_id), 32'h2);
        ack = 1'b1;
        req = 4'b0100;
        tick();
        ack = 1'b0;
        req = 4'b0000;
        check("col pend", 32'(pending), 32'h4);
        check("col ovf", 32'(overflow), 32'h0);
        check("col insvc", 32'(in_service), 32'h1);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("col gap", 32'(interrupt), 32'h0);
        tick();
        serve("col regrant", 2'd2);

        // done during REQ is ignored
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        check("done in REQ int", 32'(interrupt), 32'h1);
        check("done in REQ insvc", 32'(in_service), 32'h0);
        serve("done noise", 2'd0);

        // req[0] held high for 50 clocks gives one event
        req = 4'b0001;
        tick();
        tick();
        serve("hold", 2'd0);
        cnt = 0;
        for (int i = 0; i < 46; i++) begin
            tick();
            if (interrupt) cnt++;
        end
        check("hold extra irqs", 32'(cnt), 32'h0);
        check("hold pend", 32'(pending), 32'h0);
        req = 4'b0000;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
